// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with glitch rejection and framing-error flag.
// Optional: define UART_RX_MAJORITY_EN for a 2-of-3 vote around mid-bit.

`ifndef BAUD_RATE_115200
`define BAUD_RATE_115200 16'd434
`endif
`ifndef BAUD_RATE_57600
`define BAUD_RATE_57600 16'd868
`endif
`ifndef BAUD_RATE_38400
`define BAUD_RATE_38400 16'd1302
`endif
`ifndef BAUD_RATE_9600
`define BAUD_RATE_9600 16'd5208
`endif

module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] baud_sel,
  input  logic       rx_din,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       frame_err,
  output logic       rx_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_HIGH
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_s_d_q;

  logic [15:0] baud_div;
  logic [15:0] div_q, div_d;
  logic [15:0] half;
  logic [15:0] cnt0_q, cnt0_d;
  logic [3:0]  cnt1_q, cnt1_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  dout_q, dout_d;
  logic        vld_q, vld_d;
  logic        ferr_q, ferr_d;
  logic        busy_q;
  logic        samp_pt;
  logic        bit_v;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign half = div_q >> 1;

  always_comb begin
    baud_div = `BAUD_RATE_115200;
    unique case (baud_sel)
      2'd0: baud_div = `BAUD_RATE_115200;
      2'd1: baud_div = `BAUD_RATE_57600;
      2'd2: baud_div = `BAUD_RATE_38400;
      2'd3: baud_div = `BAUD_RATE_9600;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  logic m0_q;
  logic m1_q;

  // Vote uses the two earlier samples plus the live one at baud/2.
  assign samp_pt = (cnt0_q == half);
  assign bit_v   = (m0_q & m1_q) | (m0_q & rx_s) | (m1_q & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_q <= 1'b1;
      m1_q <= 1'b1;
    end else begin
      if (cnt0_q == half - 16'd2) m0_q <= rx_s;
      if (cnt0_q == half - 16'd1) m1_q <= rx_s;
    end
  end
`else
  assign samp_pt = (cnt0_q == half - 16'd1);
  assign bit_v   = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    shreg_d = shreg_q;
    div_d   = div_q;
    dout_d  = dout_q;
    vld_d   = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_s_d_q && !rx_s) begin
          state_d = RUN;
          cnt0_d  = '0;
          cnt1_d  = '0;
          div_d   = baud_div;
        end
      end
      RUN: begin
        if (cnt0_q == div_q - 16'd1) begin
          cnt0_d = '0;
          cnt1_d = cnt1_q + 4'd1;
        end else begin
          cnt0_d = cnt0_q + 16'd1;
        end
        if (samp_pt) begin
          unique case (1'b1)
            (cnt1_q == 4'd0): begin
              if (bit_v) state_d = IDLE;
            end
            (cnt1_q == 4'd9): begin
              // Leave at mid-stop so a back-to-back start edge is seen.
              if (bit_v) begin
                state_d = IDLE;
                dout_d  = shreg_q;
                vld_d   = 1'b1;
              end else begin
                state_d = WAIT_HIGH;
                ferr_d  = 1'b1;
              end
            end
            default: shreg_d = {bit_v, shreg_q[7:1]};
          endcase
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '1;
      rx_s_d_q <= 1'b1;
      state_q  <= IDLE;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      shreg_q  <= '0;
      div_q    <= `BAUD_RATE_115200;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      ferr_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], rx_din};
      rx_s_d_q <= rx_s;
      state_q  <= state_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
      ferr_q   <= ferr_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign frame_err = ferr_q;
  assign rx_busy   = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx (50 MHz divisors 434/868/1302/5208).
// Table of start-glitch timings per baud, plus hand-written frame sequences.

module tb_uart_rx;

  localparam int S  = 3;
  localparam int B0 = 434;
  localparam int B1 = 868;
`ifdef UART_RX_MAJORITY_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] baud_sel;
  logic       rx_din;
  logic [7:0] dout;
  logic       dout_vld;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_sel (baud_sel),
    .rx_din   (rx_din),
    .dout     (dout),
    .dout_vld (dout_vld),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         vld_cnt = 0;
  int         ferr_cnt = 0;
  int         both_cnt = 0;
  int         vld_cyc = 0;
  logic       busy_at_vld = 1'b1;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (dout_vld) begin
      vld_cnt     <= vld_cnt + 1;
      vld_cyc     <= cyc;
      busy_at_vld <= rx_busy;
      got.push_back(dout);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (dout_vld && frame_err) both_cnt <= both_cnt + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic idle(input int n);
    rx_din = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input int b, input logic stop,
                      input int glitch, output int t0);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    t0 = cyc;
    for (int k = 0; k < 10 * b; k++) begin
      rx_din = fr[k / b] ^ (k == glitch);
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [1:0] sel;
    int         div;
    int         rise;
    int         fall;
  } vec_t;

  vec_t tbl[4];
  int   t0, n0, f0, q0, rise, fall;
  logic mid_busy;
  logic [9:0] fr5;

  initial begin
    tbl[0] = '{2'd0, 434,  S + 1, S + 1 + 217 + M};
    tbl[1] = '{2'd1, 868,  S + 1, S + 1 + 434 + M};
    tbl[2] = '{2'd2, 1302, S + 1, S + 1 + 651 + M};
    tbl[3] = '{2'd3, 5208, S + 1, S + 1 + 2604 + M};

    rst_n = 1'b0;
    rx_din = 1'b1;
    baud_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_vld", dout_vld, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    idle(10);

    // Short low pulse per baud: busy rise/fall timing proves the divisor.
    for (int i = 0; i < 4; i++) begin
      baud_sel = tbl[i].sel;
      n0 = vld_cnt;
      f0 = ferr_cnt;
      rise = -1;
      fall = -1;
      t0 = cyc;
      for (int k = 0; k < 2 * tbl[i].div && fall < 0; k++) begin
        rx_din = (k < tbl[i].div / 4) ? 1'b0 : 1'b1;
        @(negedge clk);
        if (rx_busy && rise < 0) rise = cyc - t0;
        if (!rx_busy && rise >= 0 && fall < 0) fall = cyc - t0;
        @(posedge clk);
        #1;
      end
      chk($sformatf("glitch%0d_rise", i), rise, tbl[i].rise);
      chk($sformatf("glitch%0d_fall", i), fall, tbl[i].fall);
      chk($sformatf("glitch%0d_vld", i), vld_cnt - n0, 0);
      chk($sformatf("glitch%0d_ferr", i), ferr_cnt - f0, 0);
      idle(20);
    end

    baud_sel = 2'd0;
    n0 = vld_cnt;
    f0 = ferr_cnt;
    fork
      send(8'hA5, B0, 1'b1, -1, t0);
      begin
        repeat (5 * B0) @(negedge clk);
        mid_busy = rx_busy;
      end
    join
    idle(B0);
    chk("a5_count", vld_cnt - n0, 1);
    chk("a5_data", got[got.size() - 1], 8'hA5);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk_rng("a5_latency", vld_cyc - t0,
            S + 1 + 9 * B0 + B0 / 2, S + 3 + 9 * B0 + B0 / 2);
    chk("a5_busy_mid", mid_busy, 1);
    chk("a5_busy_at_vld", busy_at_vld, 0);

    baud_sel = 2'd1;
    n0 = vld_cnt;
    f0 = ferr_cnt;
    q0 = got.size();
    send(8'h00, B1, 1'b1, -1, t0);
    send(8'hFF, B1, 1'b1, -1, t0);
    idle(B1);
    chk("b2b_count", vld_cnt - n0, 2);
    chk("b2b_first", got[q0], 8'h00);
    chk("b2b_second", got[q0 + 1], 8'hFF);
    chk("b2b_ferr", ferr_cnt - f0, 0);

    baud_sel = 2'd0;
    n0 = vld_cnt;
    f0 = ferr_cnt;
    send(8'h3C, B0, 1'b0, -1, t0);
    rx_din = 1'b0;
    repeat (3 * B0) @(posedge clk);
    #1;
    chk("ferr_count", ferr_cnt - f0, 1);
    chk("ferr_no_vld", vld_cnt - n0, 0);
    chk("ferr_dout_kept", dout, 8'hFF);
    chk("ferr_busy_low_line", rx_busy, 1);
    idle(B0);
    chk("ferr_busy_released", rx_busy, 0);
    send(8'h5A, B0, 1'b1, -1, t0);
    idle(B0);
    chk("after_ferr_count", vld_cnt - n0, 1);
    chk("after_ferr_data", got[got.size() - 1], 8'h5A);
    chk("after_ferr_ferr", ferr_cnt - f0, 1);

    n0 = vld_cnt;
    f0 = ferr_cnt;
    fr5 = {1'b1, 8'h77, 1'b0};
    for (int k = 0; k < 5 * B0 + B0 / 2; k++) begin
      rx_din = fr5[k / B0];
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    rx_din = 1'b1;
    @(negedge clk);
    chk("midrst_dout", dout, 0);
    chk("midrst_busy", rx_busy, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(B0);
    chk("midrst_no_pulse", vld_cnt - n0, 0);
    chk("midrst_no_ferr", ferr_cnt - f0, 0);
    send(8'hC3, B0, 1'b1, -1, t0);
    idle(B0);
    chk("c3_data", got[got.size() - 1], 8'hC3);

    n0 = vld_cnt;
    fork
      send(8'h81, B0, 1'b1, -1, t0);
      begin
        repeat (2 * B0) @(posedge clk);
        #2;
        baud_sel = 2'd3;
      end
    join
    idle(B0);
    chk("baudchg_count", vld_cnt - n0, 1);
    chk("baudchg_data", got[got.size() - 1], 8'h81);
    baud_sel = 2'd0;
    idle(B0);

    n0 = vld_cnt;
    send(8'h96, B0, 1'b1, 3 * B0 + B0 / 2, t0);
    idle(B0);
    chk("glitch_count", vld_cnt - n0, 1);
    chk("glitch_data", got[got.size() - 1], (M != 0) ? 8'h96 : 8'h92);

    chk("vld_ferr_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
